// File: rtl/prf_bypass_regfile_pkg.sv
// Shared definitions for the physical integer register file: default geometry,
// the physical-register index type and the data word type.
package prf_bypass_regfile_pkg;

    localparam int DATA_WIDTH_DEF   = 64;
    localparam int SIZE_DEF         = 96;
    localparam int ARCH_NUM_DEF     = 32;
    localparam int READPORT_NUM_DEF = 10;
    localparam int WBPORT_NUM_DEF   = 6;
    localparam int RENAME_WIDTH_DEF = 4;
    localparam int NUMSRCS_DEF      = 2;
    localparam int HAS_ZERO_DEF     = 1;

    localparam int IPR_IDX_W = $clog2(SIZE_DEF);

    typedef logic [IPR_IDX_W-1:0]      iprIdx_t;
    typedef logic [DATA_WIDTH_DEF-1:0] data_t;

endpackage

// File: rtl/prf_bypass_regfile_rdy_table.sv
// Ready-bit scoreboard: next-ready merge of free/notready/writeback, the
// bypassed dispatch check and single-cycle protocol-error detection.
module prf_rdy_table
    import prf_bypass_regfile_pkg::*;
#(
    parameter int SIZE         = SIZE_DEF,
    parameter int ARCH_NUM     = ARCH_NUM_DEF,
    parameter int WBPORT_NUM   = WBPORT_NUM_DEF,
    parameter int RENAME_WIDTH = RENAME_WIDTH_DEF,
    parameter int NUMSRCS      = NUMSRCS_DEF,
    parameter int HAS_ZERO     = HAS_ZERO_DEF,
    parameter int IDX_W        = $clog2(SIZE)
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic [RENAME_WIDTH-1:0]                       notready_mark_i,
    input  logic [RENAME_WIDTH-1:0][IDX_W-1:0]            notready_idx_i,
    input  logic [RENAME_WIDTH-1:0]                       free_mark_i,
    input  logic [RENAME_WIDTH-1:0][IDX_W-1:0]            free_idx_i,
    input  logic [RENAME_WIDTH*NUMSRCS-1:0][IDX_W-1:0]    disp_idx_i,
    output logic [RENAME_WIDTH*NUMSRCS-1:0]               disp_vld_o,
    input  logic [WBPORT_NUM-1:0]                         write_en_i,
    input  logic [WBPORT_NUM-1:0][IDX_W-1:0]              write_idx_i,
    output logic [SIZE-1:0]                               rdy_o,
    output logic                                          err_pulse_o
);

    localparam logic [IDX_W:0] SIZE_L = (IDX_W+1)'(SIZE);

    function automatic logic in_rng(input logic [IDX_W-1:0] idx);
        return ({1'b0, idx} < SIZE_L);
    endfunction

    function automatic logic [SIZE-1:0] reset_rdy();
        logic [SIZE-1:0] r;
        for (int k = 0; k < SIZE; k++) begin
            r[k] = (k < ARCH_NUM) || ((HAS_ZERO != 0) && (k == 0));
        end
        return r;
    endfunction

    localparam logic [SIZE-1:0] RDY_RST = reset_rdy();

    logic [SIZE-1:0]       rdy_q;
    logic [SIZE-1:0]       rdy_d;
    logic [WBPORT_NUM-1:0] wr_eff_s;
    logic [WBPORT_NUM-1:0] wr_nr_s;
    logic                  err_s;

    // Per-entry merge; writeback beats allocation beats release.
    always_comb begin
        rdy_d = rdy_q;
        for (int k = 0; k < SIZE; k++) begin
            logic fr_hit;
            logic nr_hit;
            logic wr_hit;
            fr_hit = 1'b0;
            nr_hit = 1'b0;
            wr_hit = 1'b0;
            for (int l = 0; l < RENAME_WIDTH; l++) begin
                fr_hit = fr_hit | (free_mark_i[l] && (free_idx_i[l] == IDX_W'(k)));
                nr_hit = nr_hit | (notready_mark_i[l] && (notready_idx_i[l] == IDX_W'(k)));
            end
            for (int w = 0; w < WBPORT_NUM; w++) begin
                wr_hit = wr_hit | (write_en_i[w] && (write_idx_i[w] == IDX_W'(k)));
            end
            rdy_d[k] = wr_hit ? 1'b1 : (nr_hit ? 1'b0 : (fr_hit ? 1'b1 : rdy_q[k]));
            if ((HAS_ZERO != 0) && (k == 0)) begin
                rdy_d[k] = 1'b1;
            end else begin
                rdy_d[k] = rdy_d[k];
            end
        end
    end

    // Dispatch sees the bypassed next-ready view.
    always_comb begin
        disp_vld_o = '0;
        for (int i = 0; i < RENAME_WIDTH*NUMSRCS; i++) begin
            disp_vld_o[i] = in_rng(disp_idx_i[i]) ? rdy_d[disp_idx_i[i]] : 1'b0;
        end
    end

    // Classify each writeback: effective (not to the zero register) and colliding with an allocation.
    always_comb begin
        wr_eff_s = '0;
        wr_nr_s  = '0;
        for (int w = 0; w < WBPORT_NUM; w++) begin
            wr_eff_s[w] = write_en_i[w] && !((HAS_ZERO != 0) && (write_idx_i[w] == '0));
            for (int l = 0; l < RENAME_WIDTH; l++) begin
                wr_nr_s[w] = wr_nr_s[w] | (notready_mark_i[l] && (notready_idx_i[l] == write_idx_i[w]));
            end
        end
    end

    // Protocol-error detection for this cycle.
    always_comb begin
        err_s = 1'b0;
        for (int a = 0; a < WBPORT_NUM; a++) begin
            for (int b = a + 1; b < WBPORT_NUM; b++) begin
                err_s = err_s | (wr_eff_s[a] && wr_eff_s[b] && (write_idx_i[a] == write_idx_i[b]));
            end
            err_s = err_s | (wr_eff_s[a] && in_rng(write_idx_i[a]) && rdy_q[write_idx_i[a]] && !wr_nr_s[a]);
            err_s = err_s | (wr_eff_s[a] && wr_nr_s[a]);
        end
        for (int l = 0; l < RENAME_WIDTH; l++) begin
            err_s = err_s | (notready_mark_i[l] && !in_rng(notready_idx_i[l]));
            err_s = err_s | (free_mark_i[l] && !in_rng(free_idx_i[l]));
        end
    end

    // Ready-bit state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q <= RDY_RST;
        end else begin
            rdy_q <= rdy_d;
        end
    end

    assign rdy_o       = rdy_q;
    assign err_pulse_o = err_s;

endmodule

// File: rtl/prf_bypass_regfile.sv
// Physical integer register file with write-to-read bypass, registered read
// ports, a ready-bit scoreboard and a sticky protocol-error flag.
module prf_bypass_regfile
    import prf_bypass_regfile_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int SIZE         = SIZE_DEF,
    parameter int ARCH_NUM     = ARCH_NUM_DEF,
    parameter int READPORT_NUM = READPORT_NUM_DEF,
    parameter int WBPORT_NUM   = WBPORT_NUM_DEF,
    parameter int RENAME_WIDTH = RENAME_WIDTH_DEF,
    parameter int NUMSRCS      = NUMSRCS_DEF,
    parameter int HAS_ZERO     = HAS_ZERO_DEF,
    localparam int IDX_W       = $clog2(SIZE)
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [RENAME_WIDTH-1:0]                     i_notready_mark,
    input  logic [RENAME_WIDTH-1:0][IDX_W-1:0]          i_notready_iprIdx,
    input  logic [RENAME_WIDTH-1:0]                     i_free_mark,
    input  logic [RENAME_WIDTH-1:0][IDX_W-1:0]          i_free_iprIdx,
    input  logic [RENAME_WIDTH*NUMSRCS-1:0][IDX_W-1:0]  i_disp_check_iprsIdx,
    output logic [RENAME_WIDTH*NUMSRCS-1:0]             o_disp_check_iprs_vld,
    input  logic [READPORT_NUM-1:0]                     i_read_vld,
    input  logic [READPORT_NUM-1:0][IDX_W-1:0]          i_read_idx,
    output logic [READPORT_NUM-1:0]                     o_read_vld,
    output logic [READPORT_NUM-1:0]                     o_data_rdy,
    output logic [READPORT_NUM-1:0][DATA_WIDTH-1:0]     o_read_data,
    input  logic [WBPORT_NUM-1:0]                       i_write_en,
    input  logic [WBPORT_NUM-1:0][IDX_W-1:0]            i_write_idx,
    input  logic [WBPORT_NUM-1:0][DATA_WIDTH-1:0]       i_write_data,
    output logic                                        o_err
);

    localparam logic [IDX_W:0] SIZE_L = (IDX_W+1)'(SIZE);

    logic [SIZE-1:0]                          rdy_s;
    logic                                     err_pulse_s;
    logic [DATA_WIDTH-1:0]                    mem_rd_s [SIZE];
    logic [READPORT_NUM-1:0]                  rd_hit_s;
    logic [READPORT_NUM-1:0][DATA_WIDTH-1:0]  rd_byp_s;
    logic [READPORT_NUM-1:0][DATA_WIDTH-1:0]  rd_data_d;
    logic [READPORT_NUM-1:0]                  rd_rdy_d;
    logic [READPORT_NUM-1:0]                  read_vld_q;
    logic [READPORT_NUM-1:0]                  data_rdy_q;
    logic [READPORT_NUM-1:0][DATA_WIDTH-1:0]  read_data_q;
    logic                                     err_q;

    prf_rdy_table #(
        .SIZE         (SIZE),
        .ARCH_NUM     (ARCH_NUM),
        .WBPORT_NUM   (WBPORT_NUM),
        .RENAME_WIDTH (RENAME_WIDTH),
        .NUMSRCS      (NUMSRCS),
        .HAS_ZERO     (HAS_ZERO),
        .IDX_W        (IDX_W)
    ) u_rdy_table (
        .clk             (clk),
        .rst_n           (rst),
        .notready_mark_i (i_notready_mark),
        .notready_idx_i  (i_notready_iprIdx),
        .free_mark_i     (i_free_mark),
        .free_idx_i      (i_free_iprIdx),
        .disp_idx_i      (i_disp_check_iprsIdx),
        .disp_vld_o      (o_disp_check_iprs_vld),
        .write_en_i      (i_write_en),
        .write_idx_i     (i_write_idx),
        .rdy_o           (rdy_s),
        .err_pulse_o     (err_pulse_s)
    );

    // Storage entries; the zero register has no flops when hard-wired.
    for (genvar k = 0; k < SIZE; k++) begin : g_entry
        if ((HAS_ZERO != 0) && (k == 0)) begin : g_zero
            assign mem_rd_s[k] = '0;
        end else begin : g_reg
            logic                  whit_s;
            logic [DATA_WIDTH-1:0] wsel_s;
            logic [DATA_WIDTH-1:0] data_q;

            // Highest-numbered hitting write port wins.
            always_comb begin
                whit_s = 1'b0;
                wsel_s = '0;
                for (int w = 0; w < WBPORT_NUM; w++) begin
                    wsel_s = (i_write_en[w] && (i_write_idx[w] == IDX_W'(k))) ? i_write_data[w] : wsel_s;
                    whit_s = whit_s | (i_write_en[w] && (i_write_idx[w] == IDX_W'(k)));
                end
            end

            // Writes are dropped while reset is held.
            always_ff @(posedge clk) begin
                if (rst && whit_s) begin
                    data_q <= wsel_s;
                end
            end

            assign mem_rd_s[k] = data_q;
        end
    end

    // Same-cycle write bypass candidate per read port.
    always_comb begin
        rd_hit_s = '0;
        rd_byp_s = '0;
        for (int p = 0; p < READPORT_NUM; p++) begin
            for (int w = 0; w < WBPORT_NUM; w++) begin
                rd_byp_s[p] = (i_write_en[w] && (i_write_idx[w] == i_read_idx[p])) ? i_write_data[w] : rd_byp_s[p];
                rd_hit_s[p] = rd_hit_s[p] | (i_write_en[w] && (i_write_idx[w] == i_read_idx[p]));
            end
        end
    end

    // Read source select: out of range, zero register, bypass, then storage.
    always_comb begin
        rd_data_d = '0;
        rd_rdy_d  = '0;
        for (int p = 0; p < READPORT_NUM; p++) begin
            if ({1'b0, i_read_idx[p]} >= SIZE_L) begin
                rd_data_d[p] = '0;
                rd_rdy_d[p]  = 1'b0;
            end else if ((HAS_ZERO != 0) && (i_read_idx[p] == '0)) begin
                rd_data_d[p] = '0;
                rd_rdy_d[p]  = 1'b1;
            end else if (rd_hit_s[p]) begin
                rd_data_d[p] = rd_byp_s[p];
                rd_rdy_d[p]  = 1'b1;
            end else begin
                rd_data_d[p] = mem_rd_s[i_read_idx[p]];
                rd_rdy_d[p]  = rdy_s[i_read_idx[p]];
            end
        end
    end

    // Registered read outputs; data and ready hold when a port is idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_vld_q  <= '0;
            data_rdy_q  <= '0;
            read_data_q <= '0;
        end else begin
            read_vld_q <= i_read_vld;
            for (int p = 0; p < READPORT_NUM; p++) begin
                if (i_read_vld[p]) begin
                    read_data_q[p] <= rd_data_d[p];
                    data_rdy_q[p]  <= rd_rdy_d[p];
                end
            end
        end
    end

    // Sticky protocol-error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | err_pulse_s;
        end
    end

    assign o_read_vld  = read_vld_q;
    assign o_data_rdy  = data_rdy_q;
    assign o_read_data = read_data_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_prf_bypass_regfile.sv
// Directed scoreboard bench for prf_bypass_regfile: reads push expected
// responses, a negedge monitor pops and compares them.
module tb_prf_bypass_regfile;

    localparam int DW = 64;
    localparam int IW = 7;
    localparam int RP = 10;
    localparam int WB = 6;
    localparam int RW = 4;
    localparam int NS = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [RW-1:0]          nr_mark;
    logic [RW-1:0][IW-1:0]  nr_idx;
    logic [RW-1:0]          fr_mark;
    logic [RW-1:0][IW-1:0]  fr_idx;
    logic [RW*NS-1:0][IW-1:0] disp_idx;
    logic [RW*NS-1:0]       disp_vld;
    logic [RP-1:0]          rd_vld_i;
    logic [RP-1:0][IW-1:0]  rd_idx;
    logic [RP-1:0]          rd_vld_o;
    logic [RP-1:0]          rd_rdy_o;
    logic [RP-1:0][DW-1:0]  rd_data_o;
    logic [WB-1:0]          wen;
    logic [WB-1:0][IW-1:0]  widx;
    logic [WB-1:0][DW-1:0]  wdata;
    logic                   err;

    typedef struct {
        int          port;
        logic        rdy;
        logic [63:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    prf_bypass_regfile dut (
        .clk                   (clk),
        .rst                   (rst),
        .i_notready_mark       (nr_mark),
        .i_notready_iprIdx     (nr_idx),
        .i_free_mark           (fr_mark),
        .i_free_iprIdx         (fr_idx),
        .i_disp_check_iprsIdx  (disp_idx),
        .o_disp_check_iprs_vld (disp_vld),
        .i_read_vld            (rd_vld_i),
        .i_read_idx            (rd_idx),
        .o_read_vld            (rd_vld_o),
        .o_data_rdy            (rd_rdy_o),
        .o_read_data           (rd_data_o),
        .i_write_en            (wen),
        .i_write_idx           (widx),
        .i_write_data          (wdata),
        .o_err                 (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_in();
        nr_mark  = '0; nr_idx = '0;
        fr_mark  = '0; fr_idx = '0;
        disp_idx = '0;
        rd_vld_i = '0; rd_idx = '0;
        wen      = '0; widx   = '0; wdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        clear_in();
    endtask

    task automatic issue_read(input int port, input int idx, input logic rdy, input logic [63:0] data);
        rd_vld_i[port] = 1'b1;
        rd_idx[port]   = IW'(idx);
        sb_q.push_back('{port: port, rdy: rdy, data: data});
    endtask

    task automatic wr(input int port, input int idx, input logic [63:0] data);
        wen[port]   = 1'b1;
        widx[port]  = IW'(idx);
        wdata[port] = data;
    endtask

    // Monitor: every valid read response must match the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            for (int p = 0; p < RP; p++) begin
                if (rd_vld_o[p]) begin
                    if (sb_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL read_unexpected: port %0d got data 0x%0h, no response required", p, rd_data_o[p]);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        check("read_port", 64'(p), 64'(e.port));
                        check("read_rdy", 64'(rd_rdy_o[p]), 64'(e.rdy));
                        check("read_data", rd_data_o[p], e.data);
                    end
                end
            end
        end
    end

    initial begin
        clear_in();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_read_vld", 64'(rd_vld_o), 64'd0);
        check("rst_data_rdy", 64'(rd_rdy_o), 64'd0);
        check("rst_read_data", 64'(|rd_data_o), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Initial mapping and range boundaries.
        next_cycle();
        disp_idx[0] = 7'd5; disp_idx[1] = 7'd40; disp_idx[2] = 7'd31;
        disp_idx[3] = 7'd32; disp_idx[4] = 7'd100;
        @(negedge clk);
        check("disp_5", 64'(disp_vld[0]), 64'd1);
        check("disp_40", 64'(disp_vld[1]), 64'd0);
        check("disp_31", 64'(disp_vld[2]), 64'd1);
        check("disp_32", 64'(disp_vld[3]), 64'd0);
        check("disp_oor", 64'(disp_vld[4]), 64'd0);

        // Allocate 40, write it three cycles later, then read it.
        next_cycle();
        nr_mark[0] = 1'b1; nr_idx[0] = 7'd40; disp_idx[0] = 7'd40;
        @(negedge clk);
        check("disp_40_c0", 64'(disp_vld[0]), 64'd0);
        for (int c = 1; c < 3; c++) begin
            next_cycle();
            disp_idx[0] = 7'd40;
            @(negedge clk);
            check("disp_40_wait", 64'(disp_vld[0]), 64'd0);
        end
        next_cycle();
        wr(0, 40, 64'hABCD); disp_idx[0] = 7'd40;
        @(negedge clk);
        check("disp_40_bypass", 64'(disp_vld[0]), 64'd1);
        next_cycle();
        issue_read(0, 40, 1'b1, 64'hABCD);
        @(negedge clk);

        // Same-cycle write bypass and out-of-range read.
        next_cycle();
        wr(4, 50, 64'h1234);
        issue_read(2, 50, 1'b1, 64'h1234);
        issue_read(5, 100, 1'b0, 64'h0);
        @(negedge clk);

        // Zero register ignores writes.
        next_cycle();
        wr(0, 0, 64'hFFFF);
        issue_read(1, 0, 1'b1, 64'h0);
        @(negedge clk);
        next_cycle();
        issue_read(0, 0, 1'b1, 64'h0);
        @(negedge clk);
        check("err_after_zero_wr", 64'(err), 64'd0);

        // Free-list release and allocation ordering.
        next_cycle();
        fr_mark[1] = 1'b1; fr_idx[1] = 7'd60; disp_idx[0] = 7'd60;
        @(negedge clk);
        check("disp_free60", 64'(disp_vld[0]), 64'd1);
        next_cycle();
        nr_mark[2] = 1'b1; nr_idx[2] = 7'd60; fr_mark[3] = 1'b1; fr_idx[3] = 7'd61;
        disp_idx[2] = 7'd60; disp_idx[3] = 7'd61;
        @(negedge clk);
        check("disp_nr60_byp", 64'(disp_vld[2]), 64'd0);
        check("disp_fr61_byp", 64'(disp_vld[3]), 64'd1);
        next_cycle();
        disp_idx[2] = 7'd60; disp_idx[3] = 7'd61;
        @(negedge clk);
        check("disp_nr60", 64'(disp_vld[2]), 64'd0);
        check("disp_fr61", 64'(disp_vld[3]), 64'd1);
        check("err_before_dup", 64'(err), 64'd0);

        // Duplicate writeback index raises the sticky error.
        next_cycle();
        wr(1, 70, 64'h11); wr(3, 70, 64'h33);
        issue_read(0, 70, 1'b1, 64'h33);
        @(negedge clk);
        check("err_not_yet", 64'(err), 64'd0);
        next_cycle();
        issue_read(0, 70, 1'b1, 64'h33);
        @(negedge clk);
        check("err_dup_set", 64'(err), 64'd1);
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("err_sticky", 64'(err), 64'd1);

        // Asynchronous reset clears the flag and restores the mapping.
        next_cycle();
        rst = 1'b0;
        disp_idx[0] = 7'd40; disp_idx[1] = 7'd5;
        #1;
        check("err_cleared", 64'(err), 64'd0);
        check("rst2_read_vld", 64'(rd_vld_o), 64'd0);
        check("rst2_disp_40", 64'(disp_vld[0]), 64'd0);
        check("rst2_disp_5", 64'(disp_vld[1]), 64'd1);
        @(negedge clk);
        rst = 1'b1;

        // Out-of-range allocation index is a protocol error.
        next_cycle();
        nr_mark[0] = 1'b1; nr_idx[0] = 7'd100;
        @(negedge clk);
        check("err_oor_pre", 64'(err), 64'd0);
        next_cycle();
        @(negedge clk);
        check("err_oor", 64'(err), 64'd1);

        next_cycle();
        repeat (2) @(negedge clk);
        check("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prf_bypass_regfile.md
Name: prf_bypass_regfile

Overview:
Next-generation physical integer register file with a ready-bit scoreboard. It generalises data width, depth, port counts and sources per instruction, and adds:
- same-cycle write-to-read bypass;
- per-port read valid;
- free-list release of registers;
- reset-time initial architectural mapping;
- a sticky protocol-error flag.

It sits between rename/dispatch (ready marking and checks), the issue-queue read stage and the writeback network.

Parameters:
DATA_WIDTH, 64, width of each register
SIZE, 96, number of physical registers
ARCH_NUM, 32, registers 0..ARCH_NUM-1 are ready after reset (initial mapping)
READPORT_NUM, 10, number of operand read ports
WBPORT_NUM, 6, number of writeback ports
RENAME_WIDTH, 4, rename/dispatch lanes
NUMSRCS, 2, sources per instruction checked at dispatch
HAS_ZERO, 1, index 0 hard-wired to zero and always ready

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
i_notready_mark  in  RENAME_WIDTH  lane allocates a new destination
i_notready_iprIdx  in  RENAME_WIDTH x clog2(SIZE)  allocated index per lane
i_free_mark  in  RENAME_WIDTH  lane releases a register to the free list
i_free_iprIdx  in  RENAME_WIDTH x clog2(SIZE)  released index per lane
i_disp_check_iprsIdx  in  RENAME_WIDTH*NUMSRCS x clog2(SIZE)  source indices, lane-major
o_disp_check_iprs_vld  out  RENAME_WIDTH x NUMSRCS  source ready, bypassed view
i_read_vld  in  READPORT_NUM  read request per port
i_read_idx  in  READPORT_NUM x clog2(SIZE)  read index
o_read_vld  out  READPORT_NUM  registered request valid
o_data_rdy  out  READPORT_NUM  registered ready bit of the read register
o_read_data  out  READPORT_NUM x DATA_WIDTH  registered read data
i_write_en  in  WBPORT_NUM  writeback valid
i_write_idx  in  WBPORT_NUM x clog2(SIZE)  writeback index
i_write_data  in  WBPORT_NUM x DATA_WIDTH  writeback data
o_err  out  1  sticky protocol-error flag

Behaviour:
Reset (rst low, asynchronous):
- rdy[k]=1 for k<ARCH_NUM, 0 otherwise.
- o_read_vld=0, o_data_rdy=0, o_read_data=0, o_err=0.
- Register storage is not reset.
- Reset asserted mid-operation discards all in-flight reads and writes that cycle.

Next-ready computation (rdy_nxt), combinational, in increasing priority:
- start from rdy;
- free-marked index -> 1;
- notready-marked index -> 0;
- written index -> 1.
- rdy registers rdy_nxt every cycle.

Dispatch check:
- Combinational from rdy_nxt, so a same-cycle writeback is visible and a same-cycle allocation reads 0.
- Source s of lane l uses flat index l*NUMSRCS+s.

Storage:
- Write lands at the clk edge.
- HAS_ZERO=1: writes to index 0 are dropped; storage for index 0 is not built.

Read, latency 1:
- Outputs register only when i_read_vld[p]=1; otherwise o_read_data and o_data_rdy hold and o_read_vld<=0.
- Data source, in priority order:
  - HAS_ZERO=1 and idx==0: data 0, rdy 1;
  - else the highest-numbered write port hitting idx this cycle: its data, rdy 1;
  - else storage data, with rdy[idx].

o_err is set and held until reset when any of the following occurs:
- two enabled write ports share an index in one cycle (the highest-numbered port still wins);
- a write targets a register with rdy=1 that is not simultaneously notready-marked;
- any notready or free index is >= SIZE;
- the same index is both notready-marked and written in one cycle.

Index range:
- Indices >= SIZE on read return data 0 and rdy 0.

Decomposition:
- Shared package (existing core define header): iprIdx_t, the RENAME_WIDTH/NUMSRCS defaults, and a typedef for data words.
- One sub-module, prf_rdy_table. It owns rdy, rdy_nxt, the dispatch check and error detection, and exports rdy and the error pulse. Storage and read ports stay in the top.

Test Plan:
- Reset release with SIZE=96, ARCH_NUM=32: dispatch-check idx 5 -> 1; idx 40 -> 0; all read outputs 0 and o_err=0.
- notready idx 40 in cycle 0; write idx 40 data 0xABCD in cycle 3: dispatch check of 40 is 0 in cycles 1-2 and 1 in cycle 3 (bypass); read issued in cycle 4 returns 0xABCD with rdy=1 in cycle 5.
- Read idx 50 in the same cycle as a write of 0x1234 to 50 -> next cycle o_read_data=0x1234, o_data_rdy=1, o_read_vld=1.
- Read idx 0 after writing 0xFFFF to idx 0 (HAS_ZERO=1) -> data 0, rdy 1, o_err stays 0.
- Free idx 60, then in the next cycle notready 60 and free 61 together -> rdy[60]=0, rdy[61]=1.
- Ports 1 and 3 both write idx 70 (0x11 and 0x33) -> o_err=1 next cycle and stays 1; a read of 70 returns 0x33. Asserting rst clears o_err.
